seq_alu: RTL

Parametrised, registered ALU with a start/done handshake and a 4-bit flag set. It keeps the 8-op arithmetic/logic repertoire and adds logical/arithmetic shifts and an iterative shift-add multiply. All results and flags are registered, and operands are latched at start. It sits between the register file/accumulator and the control sequencer, which issues `start` and waits for `done`.

---
 rtl/seq_alu.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: single-cycle arithmetic, logic and shift ops,
// plus an iterative shift-add multiply. Flags are {V, N, C, Z}.
module seq_alu #(
    parameter int W  = 16,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [W:0]  ONE_EXT  = {{W{1'b0}}, 1'b1};
    localparam logic [SW:0] CNT_INIT = (SW+1)'(W);
    localparam logic [SW:0] CNT_ONE  = {{SW{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [W-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [SW:0]     count_q, count_d;

    logic [W:0]         sum_ext, diff_ext, inc_ext, dec_ext;
    logic [W:0]         shl_ext, shr_ext;
    logic signed [W:0]  sar_ext;
    logic [SW-1:0]      amt;
    logic [W-1:0]       alu_res;
    logic               alu_c, alu_v;
    logic [2*W-1:0]     acc_step;

    function automatic logic [3:0] pack_flags(input logic [W-1:0] r,
                                              input logic c, input logic v);
        return {v, r[W-1], c, (r == '0)};
    endfunction

    // Single-cycle datapath; carry/borrow come from the extra top bit.
    always_comb begin
        amt      = b[SW-1:0];
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        inc_ext  = {1'b0, a} + ONE_EXT;
        dec_ext  = {1'b0, a} - ONE_EXT;
        shl_ext  = {1'b0, a} << amt;
        shr_ext  = {a, 1'b0} >> amt;
        sar_ext  = $signed({a, 1'b0}) >>> amt;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_v   = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[W-1:0];
                alu_c   = diff_ext[W];
                alu_v   = (a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]);
            end
            OP_INC: begin
                alu_res = inc_ext[W-1:0];
                alu_c   = inc_ext[W];
                alu_v   = !a[W-1] && inc_ext[W-1];
            end
            OP_DEC: begin
                alu_res = dec_ext[W-1:0];
                alu_c   = dec_ext[W];
                alu_v   = a[W-1] && !dec_ext[W-1];
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = shl_ext[W-1:0];
                alu_c   = shl_ext[W];
            end
            OP_SHR: begin
                alu_res = shr_ext[W:1];
                alu_c   = shr_ext[0];
            end
            OP_SAR: begin
                alu_res = sar_ext[W:1];
                alu_c   = sar_ext[0];
            end
            default: ;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = CNT_INIT;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        flags_d  = pack_flags(alu_res, alu_c, alu_v);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_ONE;
                // Last iteration: publish the finished low half straight from the adder.
                if (count_q == CNT_ONE) begin
                    result_d = acc_step[W-1:0];
                    flags_d  = pack_flags(acc_step[W-1:0], |acc_step[2*W-1:W], 1'b0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule
